i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 177 +++++++++++++++++
 tb/tb_i2c_slave.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 2-flop synchronised SCL/SDA, LSB-first bytes, ACK generation and read shifting.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address byte 8'h00 as a write.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h52
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      RX       = 3'd3,
      RX_ACK   = 3'd4,
      TX       = 3'd5,
      TX_ACK   = 3'd6,
      IGNORE   = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic       busy_q, busy_d, sda_out_q, sda_out_d;

   logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_hit;
   logic [7:0] byte_in;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign byte_in   = {sda_s, shift_q[7:1]};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
   assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) || (byte_in == 8'h00);
`else
   assign addr_hit = (byte_in[7:1] == SLAVE_ADDR);
`endif

   always_comb begin
      // NOTE: every *_d gets a default first so no path can infer a latch.
      scl_sync_d = {scl_sync_q[0], sclk};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;
      sda_out_d  = sda_out_q;

      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         sda_out_d = 1'b1;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 3'd0;
         sda_out_d = 1'b1;
      end else begin
         case (state_q)
            ADDR, RX: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == RX) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = RX_ACK;
                     end else if (addr_hit) begin
                        state_d = ADDR_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d   = IGNORE;
                        sda_out_d = 1'b1;
                     end
                  end
               end
            end
            // First SCL fall pulls ACK low, the second ends the ACK bit.
            ADDR_ACK, RX_ACK: begin
               if (scl_fall) begin
                  if (sda_out_q) begin
                     sda_out_d = 1'b0;
                  end else if (state_q == ADDR_ACK && shift_q[0]) begin
                     state_d   = TX;
                     shift_d   = tx_data;
                     tx_req_d  = 1'b1;
                     sda_out_d = tx_data[0];
                  end else begin
                     state_d   = RX;
                     sda_out_d = 1'b1;
                  end
               end
            end
            TX: begin
               if (scl_fall) sda_out_d = shift_q[bit_cnt_q];
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = TX_ACK;
               end
            end
            TX_ACK: begin
               if (scl_fall) sda_out_d = 1'b1;
               if (scl_rise) begin
                  if (!sda_s) begin
                     state_d  = TX;
                     shift_d  = tx_data;
                     tx_req_d = 1'b1;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            IGNORE:  sda_out_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         sda_out_q  <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
         sda_out_q  <= sda_out_d;
      end
   end

   assign sda_out  = sda_out_q;
   assign tx_req   = tx_req_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign state    = state_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave through a wired-AND SDA bus,
// checked against a transaction-level model of addressing, ACKs and byte transfers.
module tb_i2c_slave;
   localparam int HQ = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       m_scl, m_sda;
   logic       sda_out, tx_req, rx_valid, busy;
   logic [7:0] tx_data, rx_data;
   logic [2:0] state;
   logic       sda_bus;

   int n_total = 0;
   int n_pass  = 0;
   int rxv_cnt = 0, txr_cnt = 0, sda_low_cnt = 0, busy_cnt = 0;
   logic [7:0] exp_rx = 8'h00;

   assign sda_bus = m_sda & sda_out;

   i2c_slave dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (m_scl),
      .sda_in   (sda_bus),
      .sda_out  (sda_out),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .state    (state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) rxv_cnt <= rxv_cnt + 1;
         if (tx_req) txr_cnt <= txr_cnt + 1;
         if (!sda_out) sda_low_cnt <= sda_low_cnt + 1;
         if (busy) busy_cnt <= busy_cnt + 1;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference model: which address bytes this target answers.
   function automatic logic model_match(input logic [7:0] a);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      return (a[7:1] == 7'h52) || (a == 8'h00);
`else
      return a[7:1] == 7'h52;
`endif
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_cond();
      if (m_scl) begin
         m_sda = 1'b0; wait_clk(HQ);
         m_scl = 1'b0; wait_clk(HQ);
      end else begin
         m_sda = 1'b1; wait_clk(HQ);
         m_scl = 1'b1; wait_clk(HQ);
         m_sda = 1'b0; wait_clk(HQ);
         m_scl = 1'b0; wait_clk(HQ);
      end
   endtask

   task automatic stop_cond();
      m_sda = 1'b0; wait_clk(HQ);
      m_scl = 1'b1; wait_clk(HQ);
      m_sda = 1'b1; wait_clk(2 * HQ);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      m_sda = b;    wait_clk(HQ);
      m_scl = 1'b1; wait_clk(HQ);
      s = sda_bus;  wait_clk(HQ);
      m_scl = 1'b0; wait_clk(HQ);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 0; i < 8; i++) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_tx);
      logic s;
      logic [7:0] tmp;
      tmp = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, s);
         tmp[i] = s;
      end
      tx_data = next_tx;
      clock_bit(nack, s);
      d = tmp;
   endtask

   task automatic test_reset();
      rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
      wait_clk(4);
      n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
      n_total++; if (sda_out !== 1'b1) $display("FAIL reset_sda_out: got %b expected 1", sda_out); else n_pass++;
      n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
      n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
      n_total++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b expected 0", tx_req); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      rst = 1'b0;
      wait_clk(4);
      n_total++; if (state !== 3'd0) $display("FAIL post_reset_state: got %0d expected 0", state); else n_pass++;
   endtask

   task automatic test_write();
      logic ack;
      int rxv0;
      rxv0 = rxv_cnt;
      start_cond();
      write_byte(8'hA4, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL write_addr_ack: got %b expected 0", ack); else n_pass++;
      write_byte(8'h3C, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL write_data_ack: got %b expected 0", ack); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL write_busy: got %b expected 1", busy); else n_pass++;
      stop_cond();
      exp_rx = 8'h3C;
      n_total++; if (rx_data !== exp_rx) $display("FAIL write_rx_data: got %h expected %h", rx_data, exp_rx); else n_pass++;
      n_total++; if (rxv_cnt - rxv0 !== 1) $display("FAIL write_rx_valid_count: got %0d expected 1", rxv_cnt - rxv0); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b expected 0", busy); else n_pass++;
      n_total++; if (state !== 3'd0) $display("FAIL write_state_after_stop: got %0d expected 0", state); else n_pass++;
   endtask

   task automatic test_read();
      logic ack;
      logic [7:0] d;
      int txr0;
      txr0 = txr_cnt;
      tx_data = 8'h96;
      start_cond();
      write_byte(8'hA5, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL read_addr_ack: got %b expected 0", ack); else n_pass++;
      read_byte(d, 1'b1, 8'h00);
      n_total++; if (d !== 8'h96) $display("FAIL read_bus_bits: got %h expected 96", d); else n_pass++;
      n_total++; if (txr_cnt - txr0 !== 1) $display("FAIL read_tx_req_count: got %0d expected 1", txr_cnt - txr0); else n_pass++;
      n_total++; if (state !== 3'd7) $display("FAIL read_state_after_nack: got %0d expected 7", state); else n_pass++;
      stop_cond();
      n_total++; if (state !== 3'd0) $display("FAIL read_state_after_stop: got %0d expected 0", state); else n_pass++;
   endtask

   task automatic test_mismatch();
      logic ack;
      int low0, busy0, rxv0;
      low0 = sda_low_cnt; busy0 = busy_cnt; rxv0 = rxv_cnt;
      start_cond();
      write_byte(8'hB4, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL mismatch_addr_ack: got %b expected 1", ack); else n_pass++;
      write_byte(8'h5A, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL mismatch_data_ack: got %b expected 1", ack); else n_pass++;
      stop_cond();
      n_total++; if (sda_low_cnt !== low0) $display("FAIL mismatch_sda_low_cycles: got %0d expected 0", sda_low_cnt - low0); else n_pass++;
      n_total++; if (busy_cnt !== busy0) $display("FAIL mismatch_busy_cycles: got %0d expected 0", busy_cnt - busy0); else n_pass++;
      n_total++; if (rxv_cnt !== rxv0) $display("FAIL mismatch_rx_valid: got %0d expected 0", rxv_cnt - rxv0); else n_pass++;
   endtask

   task automatic test_stop_mid_byte();
      logic ack, s;
      int rxv0;
      rxv0 = rxv_cnt;
      start_cond();
      write_byte(8'hA4, ack);
      for (int i = 0; i < 4; i++) clock_bit(i[0], s);
      stop_cond();
      n_total++; if (state !== 3'd0) $display("FAIL partial_state: got %0d expected 0", state); else n_pass++;
      n_total++; if (rx_data !== exp_rx) $display("FAIL partial_rx_data: got %h expected %h", rx_data, exp_rx); else n_pass++;
      n_total++; if (rxv_cnt !== rxv0) $display("FAIL partial_rx_valid: got %0d expected 0", rxv_cnt - rxv0); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_repeated_start();
      logic ack, s;
      logic [7:0] b;
      b = 8'($urandom);
      start_cond();
      write_byte(8'hA4, ack);
      for (int i = 0; i < 3; i++) clock_bit(1'b0, s);
      start_cond();
      n_total++; if (state !== 3'd1) $display("FAIL rstart_state: got %0d expected 1", state); else n_pass++;
      n_total++; if (sda_out !== 1'b1) $display("FAIL rstart_sda_out: got %b expected 1", sda_out); else n_pass++;
      write_byte(8'hA4, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL rstart_addr_ack: got %b expected 0", ack); else n_pass++;
      write_byte(b, ack);
      stop_cond();
      exp_rx = b;
      n_total++; if (rx_data !== exp_rx) $display("FAIL rstart_rx_data: got %h expected %h", rx_data, exp_rx); else n_pass++;
   endtask

   task automatic test_reset_mid_ack();
      logic ack, s;
      start_cond();
      for (int i = 0; i < 8; i++) clock_bit(i inside {2, 5, 7}, s);
      n_total++; if (state !== 3'd2) $display("FAIL ack_phase_state: got %0d expected 2", state); else n_pass++;
      n_total++; if (sda_out !== 1'b0) $display("FAIL ack_phase_sda_out: got %b expected 0", sda_out); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_total++; if (sda_out !== 1'b1) $display("FAIL async_reset_sda_out: got %b expected 1", sda_out); else n_pass++;
      n_total++; if (state !== 3'd0) $display("FAIL async_reset_state: got %0d expected 0", state); else n_pass++;
      exp_rx = 8'h00;
      m_sda = 1'b1; wait_clk(HQ);
      m_scl = 1'b1; wait_clk(HQ);
      rst = 1'b0;   wait_clk(HQ);
      start_cond();
      write_byte(8'hA4, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL after_reset_addr_ack: got %b expected 0", ack); else n_pass++;
      write_byte(8'h11, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL after_reset_data_ack: got %b expected 0", ack); else n_pass++;
      stop_cond();
      exp_rx = 8'h11;
      n_total++; if (rx_data !== exp_rx) $display("FAIL after_reset_rx_data: got %h expected %h", rx_data, exp_rx); else n_pass++;
   endtask

   task automatic test_general_call();
      logic ack, exp_ack;
      logic [7:0] b;
      int rxv0;
      rxv0 = rxv_cnt;
      b = 8'($urandom);
      exp_ack = ~model_match(8'h00);
      start_cond();
      write_byte(8'h00, ack);
      n_total++; if (ack !== exp_ack) $display("FAIL gcall_addr_ack: got %b expected %b", ack, exp_ack); else n_pass++;
      write_byte(b, ack);
      stop_cond();
      if (!exp_ack) exp_rx = b;
      n_total++; if (rx_data !== exp_rx) $display("FAIL gcall_rx_data: got %h expected %h", rx_data, exp_rx); else n_pass++;
      n_total++; if (rxv_cnt - rxv0 !== (exp_ack ? 0 : 1)) $display("FAIL gcall_rx_valid: got %0d expected %0d", rxv_cnt - rxv0, exp_ack ? 0 : 1); else n_pass++;
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         logic [7:0] a, got;
         logic [7:0] q[$];
         logic ack, m;
         int n, rxv0, txr0;
         case ($urandom_range(0, 3))
            0: a = 8'hA4;
            1: a = 8'hA5;
            default: a = 8'($urandom);
         endcase
         m = model_match(a);
         n = $urandom_range(1, 3);
         q.delete();
         for (int k = 0; k < n; k++) q.push_back(8'($urandom));
         rxv0 = rxv_cnt; txr0 = txr_cnt;
         tx_data = q[0];
         start_cond();
         write_byte(a, ack);
         n_total++; if (ack !== !m) $display("FAIL rand%0d_addr_ack: addr %h got %b expected %b", t, a, ack, !m); else n_pass++;
         if (!a[0]) begin
            for (int k = 0; k < n; k++) begin
               write_byte(q[k], ack);
               n_total++; if (ack !== !m) $display("FAIL rand%0d_data_ack%0d: got %b expected %b", t, k, ack, !m); else n_pass++;
            end
            n_total++; if (busy !== m) $display("FAIL rand%0d_busy: got %b expected %b", t, busy, m); else n_pass++;
            stop_cond();
            if (m) exp_rx = q[n-1];
            n_total++; if (rx_data !== exp_rx) $display("FAIL rand%0d_rx_data: got %h expected %h", t, rx_data, exp_rx); else n_pass++;
            n_total++; if (rxv_cnt - rxv0 !== (m ? n : 0)) $display("FAIL rand%0d_rx_valid: got %0d expected %0d", t, rxv_cnt - rxv0, m ? n : 0); else n_pass++;
         end else begin
            for (int k = 0; k < n; k++) begin
               read_byte(got, k == n - 1, (k + 1 < n) ? q[k+1] : 8'h00);
               n_total++; if (got !== (m ? q[k] : 8'hFF)) $display("FAIL rand%0d_read%0d: got %h expected %h", t, k, got, m ? q[k] : 8'hFF); else n_pass++;
            end
            n_total++; if (state !== 3'd7) $display("FAIL rand%0d_state_after_nack: got %0d expected 7", t, state); else n_pass++;
            stop_cond();
            n_total++; if (txr_cnt - txr0 !== (m ? n : 0)) $display("FAIL rand%0d_tx_req: got %0d expected %0d", t, txr_cnt - txr0, m ? n : 0); else n_pass++;
         end
         n_total++; if (state !== 3'd0 || busy !== 1'b0) $display("FAIL rand%0d_idle: state %0d busy %b expected 0 0", t, state, busy); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_stop_mid_byte();
      test_repeated_start();
      test_reset_mid_ack();
      test_general_call();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
